// File: rtl/uart_rx_if.sv
// Serial-receive bundle: the line in, plus the recovered byte and its status strobes.
// The master side drives the line (pin/bench); the slave side is the receiver.
interface uart_rx_if #(
   parameter int BIT_MAX = 8
);
   logic               rx;
   logic [BIT_MAX-1:0] rx_data;
   logic               rx_valid;
   logic               frame_err;
   logic               rx_busy;

   modport master (
      output rx,
      input  rx_data, rx_valid, frame_err, rx_busy
   );

   modport slave (
      input  rx,
      output rx_data, rx_valid, frame_err, rx_busy
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the async line, finds the start edge, samples each bit
// mid-period and emits a one-cycle rx_valid (good stop) or frame_err (bad stop) strobe.
module uart_rx #(
   parameter int BPS_MAX = 5208,
   parameter int BIT_MAX = 8
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);

   localparam int BPS_W = ($clog2(BPS_MAX) < 13) ? 13 : $clog2(BPS_MAX);
   localparam int BIT_W = $clog2(BIT_MAX) + 1;

   localparam logic [BPS_W-1:0] BPS_LAST = BPS_W'(BPS_MAX - 1);
   localparam logic [BPS_W-1:0] BPS_HALF = BPS_W'(BPS_MAX / 2 - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_MAX - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t             r_state;
   logic [BPS_W-1:0]   r_bpsCnt;
   logic [BIT_W-1:0]   r_bitCnt;
   logic [BIT_MAX-1:0] r_shift;
   logic [BIT_MAX-1:0] r_rxData;
   logic               r_rxValid;
   logic               r_frameErr;
   logic               r_s1;
   logic               r_s2;
   logic               r_s3;
   logic               w_fall;

   assign w_fall = r_s3 & ~r_s2;

   // Synchroniser, edge detect and frame FSM share one clocked block; strobes default low.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_bpsCnt   <= '0;
         r_bitCnt   <= '0;
         r_shift    <= '0;
         r_rxData   <= '0;
         r_rxValid  <= 1'b0;
         r_frameErr <= 1'b0;
         r_s1       <= 1'b1;
         r_s2       <= 1'b1;
         r_s3       <= 1'b1;
      end else begin
         r_s1       <= bus.rx;
         r_s2       <= r_s1;
         r_s3       <= r_s2;
         r_rxValid  <= 1'b0;
         r_frameErr <= 1'b0;

         case (r_state)
            IDLE: begin
               r_bpsCnt <= '0;
               if (w_fall) begin
                  r_state <= START;
               end
            end

            // Half a bit in: still low means a real start bit, and later samples land mid-bit.
            START: begin
               if (r_bpsCnt == BPS_HALF) begin
                  r_bpsCnt <= '0;
                  if (!r_s2) begin
                     r_state  <= DATA;
                     r_bitCnt <= '0;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_bpsCnt <= r_bpsCnt + 1'b1;
               end
            end

            DATA: begin
               if (r_bpsCnt == BPS_LAST) begin
                  r_bpsCnt <= '0;
                  r_shift  <= {r_s2, r_shift[BIT_MAX-1:1]};
                  r_bitCnt <= r_bitCnt + 1'b1;
                  if (r_bitCnt == BIT_LAST) begin
                     r_state <= STOP;
                  end
               end else begin
                  r_bpsCnt <= r_bpsCnt + 1'b1;
               end
            end

            // Returning to IDLE mid-stop-bit leaves time to catch a back-to-back start edge.
            STOP: begin
               if (r_bpsCnt == BPS_LAST) begin
                  r_bpsCnt <= '0;
                  r_state  <= IDLE;
                  if (r_s2) begin
                     r_rxData  <= r_shift;
                     r_rxValid <= 1'b1;
                  end else begin
                     r_frameErr <= 1'b1;
                  end
               end else begin
                  r_bpsCnt <= r_bpsCnt + 1'b1;
               end
            end

            default: begin
               r_state  <= IDLE;
               r_bpsCnt <= '0;
            end
         endcase
      end
   end

   assign bus.rx_data   = r_rxData;
   assign bus.rx_valid  = r_rxValid;
   assign bus.frame_err = r_frameErr;
   assign bus.rx_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames driven onto the line, expected strobes queued in a
// scoreboard and matched by a negedge monitor, plus glitch and mid-frame reset sequences.
module tb_uart_rx;

   localparam int BPS = 16;

   typedef struct {
      logic [7:0] data;
      logic       stopBit;
      int         idleBits;
   } vec_t;

   typedef struct {
      logic       isErr;
      logic [7:0] data;
   } exp_t;

   logic clk;
   logic rst;

   uart_rx_if #(.BIT_MAX(8)) bus ();

   uart_rx #(
      .BPS_MAX(BPS),
      .BIT_MAX(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int         checkCount = 0;
   int         passCount  = 0;
   exp_t       sbQueue[$];
   logic [7:0] lastGood = 8'h00;
   logic       lastBusy = 1'b0;
   exp_t       monExp;
   vec_t       vecs[5];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison goes through here so the counts stay in one place.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sendFrame(input logic [7:0] data, input logic stopBit);
      bus.rx = 1'b0;
      repeat (BPS) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = data[i];
         repeat (BPS) @(posedge clk);
      end
      bus.rx = stopBit;
      repeat (BPS) @(posedge clk);
   endtask

   // Queue what the receiver should report, then put the frame on the line.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      exp_t e;
      e.isErr = ~stopBit;
      e.data  = stopBit ? data : lastGood;
      if (stopBit) lastGood = data;
      sbQueue.push_back(e);
      sendFrame(data, stopBit);
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while (sbQueue.size() != 0 && n < 40 * BPS) begin
         @(posedge clk);
         n++;
      end
      checkOutput(name, sbQueue.size(), 0);
   endtask

   // Every strobe must match the head of the scoreboard; a strobe with nothing queued fails.
   always @(negedge clk) begin
      if (rst && (bus.rx_valid || bus.frame_err)) begin
         checkOutput("strobeExclusive", {31'd0, bus.rx_valid & bus.frame_err}, 0);
         if (sbQueue.size() == 0) begin
            checkOutput("unexpectedStrobe", sbQueue.size(), 1);
         end else begin
            monExp = sbQueue.pop_front();
            checkOutput("strobeKind", {31'd0, bus.frame_err}, {31'd0, monExp.isErr});
            checkOutput("rxData", {24'd0, bus.rx_data}, {24'd0, monExp.data});
            checkOutput("busyFall", {30'd0, lastBusy, bus.rx_busy}, 32'd2);
         end
      end
      lastBusy = bus.rx_busy;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{data: 8'hA5, stopBit: 1'b1, idleBits: 2};
      vecs[1] = '{data: 8'h00, stopBit: 1'b1, idleBits: 0};
      vecs[2] = '{data: 8'hFF, stopBit: 1'b1, idleBits: 0};
      vecs[3] = '{data: 8'h55, stopBit: 1'b1, idleBits: 2};
      vecs[4] = '{data: 8'h3C, stopBit: 1'b0, idleBits: 2};

      rst    = 1'b0;
      bus.rx = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.rx = i[0];
         @(posedge clk);
      end
      @(negedge clk);
      checkOutput("resetData",  {24'd0, bus.rx_data}, 0);
      checkOutput("resetValid", {31'd0, bus.rx_valid}, 0);
      checkOutput("resetErr",   {31'd0, bus.frame_err}, 0);
      checkOutput("resetBusy",  {31'd0, bus.rx_busy}, 0);
      bus.rx = 1'b1;
      @(posedge clk);
      rst = 1'b1;
      repeat (2 * BPS) @(posedge clk);

      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].data, vecs[v].stopBit);
         if (vecs[v].idleBits > 0) begin
            bus.rx = 1'b1;
            repeat (vecs[v].idleBits * BPS) @(posedge clk);
         end
      end
      waitDrain("tableDrain");
      checkOutput("dataAfterErr", {24'd0, bus.rx_data}, 32'h55);

      // Short low pulse on an idle line: start bit rejected at its midpoint.
      bus.rx = 1'b0;
      repeat (3) @(posedge clk);
      bus.rx = 1'b1;
      repeat (BPS - 3) @(posedge clk);
      @(negedge clk);
      checkOutput("glitchIdle", {31'd0, bus.rx_busy}, 0);
      repeat (2 * BPS) @(posedge clk);

      // Reset pulse during data bit 4 of an all-ones frame: aborted without any strobe.
      fork
         sendFrame(8'hFF, 1'b1);
         begin
            repeat (BPS + 4 * BPS + BPS / 2) @(posedge clk);
            rst = 1'b0;
            repeat (3) @(posedge clk);
            rst = 1'b1;
         end
      join
      lastGood = 8'h00;
      @(negedge clk);
      checkOutput("resetClearsData", {24'd0, bus.rx_data}, 0);
      checkOutput("resetIdle", {31'd0, bus.rx_busy}, 0);
      bus.rx = 1'b1;
      repeat (2 * BPS) @(posedge clk);

      applyStimulus(8'h81, 1'b1);
      bus.rx = 1'b1;
      repeat (2 * BPS) @(posedge clk);
      waitDrain("postResetDrain");
      checkOutput("finalData", {24'd0, bus.rx_data}, 32'h81);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
